// File: rtl/proj_seq_ctrl_pkg.sv
// Shared types and widths for the projection sequencer and related projection blocks.
// No logic; no latency or backpressure of its own.
// Consumers import this with proj_seq_ctrl_pkg::*.
package proj_seq_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int FCNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_VS,
    S_ACCUM,
    S_SCAN,
    S_PUBLISH
  } seq_state_t;

endpackage

// File: rtl/proj_seq_ctrl_vs_edge_det.sv
// Frame sync edge detector: compares vs with its registered copy.
// Latency: rise/fall are valid in the cycle vs first differs from its copy, so the consumer acts one edge later.
// No backpressure; edges are single-cycle strobes.
module vs_edge_det (
  input  logic pixelclk,
  input  logic reset,
  input  logic vs,
  output logic rise,
  output logic fall
);

  logic vs_q;

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs;
    end
  end

  assign rise = vs & ~vs_q;
  assign fall = ~vs & vs_q;

endmodule

// File: rtl/proj_seq_ctrl.sv
// Projection RAM sequencer: clear, accumulate per frame, scan, and publish every FRAME_DIV frames; PROJ_SEQ_OVERRUN_CNT_EN adds an overrun counter.
// Latency: ACCUM writes are combinational pass-through; scan data is marked one cycle after each read address.
// No backpressure: frame starts arriving outside WAIT_VS are dropped and flagged as overruns.
module proj_seq_ctrl
  import proj_seq_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH_LINE = 1920,
  parameter int FRAME_DIV      = 4
) (
  input  logic              pixelclk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_vs,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_di,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              scan_first,
  output logic              scan_last,
  output logic              result_stb,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        overrun_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_WIDTH_LINE - 1);
  localparam logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(IMG_WIDTH_LINE);
  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FRAME_DIV - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, addr_cnt_nxt;
  logic [FCNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic              overrun_q;
  logic              rise, fall;
  logic              we_c, di_c, issue_c, stb_c, missed_c, ovr_clr_c;
  logic [ADDR_W-1:0] waddr_c, raddr_c;
  logic [7:0]        ovr_cnt_q;

  vs_edge_det u_vs_edge_det (
    .pixelclk (pixelclk),
    .reset    (reset),
    .vs       (i_vs),
    .rise     (rise),
    .fall     (fall)
  );

  always_comb begin
    state_nxt     = state;
    addr_cnt_nxt  = addr_cnt;
    frame_cnt_nxt = frame_cnt;
    we_c          = 1'b0;
    waddr_c       = '0;
    di_c          = 1'b0;
    raddr_c       = '0;
    issue_c       = 1'b0;
    stb_c         = 1'b0;
    missed_c      = 1'b0;
    ovr_clr_c     = 1'b0;
    case (state)
      S_IDLE: begin
        frame_cnt_nxt = '0;
        addr_cnt_nxt  = '0;
        if (i_en) begin
          state_nxt = S_CLEAR;
          ovr_clr_c = 1'b1;
        end
      end
      S_CLEAR: begin
        we_c     = 1'b1;
        waddr_c  = addr_cnt;
        missed_c = rise;
        if (addr_cnt == LAST_ADDR) begin
          addr_cnt_nxt = '0;
          state_nxt    = i_en ? S_WAIT_VS : S_IDLE;
        end else begin
          addr_cnt_nxt = addr_cnt + ADDR_W'(1);
        end
      end
      S_WAIT_VS: begin
        if (!i_en) state_nxt = S_IDLE;
        else if (rise) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (i_wr_req && ({20'd0, i_wr_addr} < 32'(IMG_WIDTH_LINE))) begin
          we_c    = 1'b1;
          waddr_c = i_wr_addr;
          di_c    = 1'b1;
        end
        if (!i_en) state_nxt = S_IDLE;
        else if (fall) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        missed_c = rise;
        if (addr_cnt != END_ADDR) begin
          issue_c      = 1'b1;
          raddr_c      = addr_cnt;
          addr_cnt_nxt = addr_cnt + ADDR_W'(1);
        end
        // Leave only once the final read's data has been presented.
        if (vld_q && (addr_q == LAST_ADDR)) begin
          addr_cnt_nxt = '0;
          if (!i_en) begin
            state_nxt = S_IDLE;
          end else if (frame_cnt == LAST_FRAME) begin
            frame_cnt_nxt = '0;
            state_nxt     = S_PUBLISH;
          end else begin
            frame_cnt_nxt = frame_cnt + FCNT_W'(1);
            state_nxt     = S_CLEAR;
          end
        end
      end
      S_PUBLISH: begin
        stb_c     = 1'b1;
        missed_c  = rise;
        state_nxt = S_CLEAR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      frame_cnt <= '0;
      vld_q     <= 1'b0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_cnt  <= addr_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      vld_q     <= issue_c;
      addr_q    <= issue_c ? addr_cnt : '0;
      if (ovr_clr_c) overrun_q <= 1'b0;
      else if (missed_c) overrun_q <= 1'b1;
    end
  end

`ifdef PROJ_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge pixelclk) begin
    if (reset || ovr_clr_c) begin
      ovr_cnt_q <= '0;
    end else if (missed_c && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end
`else
  assign ovr_cnt_q = '0;
`endif

  // Outputs are forced low while reset is held so nothing leaks before the first edge.
  assign ram_we      = we_c & ~reset;
  assign ram_waddr   = reset ? '0 : waddr_c;
  assign ram_di      = di_c & ~reset;
  assign ram_raddr   = reset ? '0 : raddr_c;
  assign scan_valid  = vld_q & ~reset;
  assign scan_addr   = reset ? '0 : addr_q;
  assign scan_first  = vld_q & ~reset & (addr_q == '0);
  assign scan_last   = vld_q & ~reset & (addr_q == LAST_ADDR);
  assign result_stb  = stb_c & ~reset;
  assign busy        = (state != S_IDLE) & ~reset;
  assign overrun     = overrun_q & ~reset;
  assign overrun_cnt = reset ? '0 : ovr_cnt_q;

endmodule

// File: tb/tb_proj_seq_ctrl.sv
// Directed bench for proj_seq_ctrl with a write/scan scoreboard; PROJ_SEQ_OVERRUN_CNT_EN selects the counter expectations.
module tb_proj_seq_ctrl;

  localparam int W  = 16;
  localparam int FD = 4;
`ifdef PROJ_SEQ_OVERRUN_CNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
  localparam logic [7:0] CNT_SAT = 8'd255;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
  localparam logic [7:0] CNT_SAT = 8'd0;
`endif

  logic        pixelclk = 1'b0;
  logic        reset = 1'b1;
  logic        i_en = 1'b0;
  logic        i_vs = 1'b0;
  logic        i_wr_req = 1'b0;
  logic [11:0] i_wr_addr = '0;
  logic        ram_we, ram_di, scan_valid, scan_first, scan_last, result_stb, busy, overrun;
  logic [11:0] ram_waddr, ram_raddr, scan_addr;
  logic [7:0]  overrun_cnt;
  logic [51:0] all_outs;

  proj_seq_ctrl #(.IMG_WIDTH_LINE(W), .FRAME_DIV(FD)) dut (
    .pixelclk(pixelclk), .reset(reset), .i_en(i_en), .i_vs(i_vs),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_di(ram_di), .ram_raddr(ram_raddr),
    .scan_valid(scan_valid), .scan_addr(scan_addr), .scan_first(scan_first),
    .scan_last(scan_last), .result_stb(result_stb), .busy(busy),
    .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  assign all_outs = {ram_we, ram_waddr, ram_di, ram_raddr, scan_valid, scan_addr,
                     scan_first, scan_last, result_stb, busy, overrun, overrun_cnt};

  always #5 pixelclk = ~pixelclk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [12:0] wq[$];
  logic [13:0] sq[$];
  int          stb_log[$];
  int          scan_done_cnt = 0;
  int          stb_cycles = 0;
  int          stb_before;
  bit          mon_off = 1'b0;
  bit          stb_prev = 1'b0;
  logic [12:0] we_e;
  logic [13:0] s_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops expected RAM writes and scan beats as the DUT produces them.
  always @(negedge pixelclk) begin
    if (!mon_off) begin
      if (ram_we) begin
        if (wq.size() == 0) chk("we_unexpected", {63'd0, ram_we}, 64'd0);
        else begin
          we_e = wq.pop_front();
          chk("ram_write", {51'd0, ram_waddr, ram_di}, {51'd0, we_e});
        end
      end
      if (scan_valid) begin
        if (sq.size() == 0) chk("scan_unexpected", {63'd0, scan_valid}, 64'd0);
        else begin
          s_e = sq.pop_front();
          chk("scan_beat", {50'd0, scan_addr, scan_first, scan_last}, {50'd0, s_e});
        end
        if (scan_last) scan_done_cnt++;
      end
    end
    if (result_stb) begin
      stb_cycles++;
      if (!stb_prev) stb_log.push_back(scan_done_cnt);
    end
    stb_prev = result_stb;
  end

  task automatic wait_wq_empty(input string tag);
    int n = 0;
    while (wq.size() != 0 && n < 200) begin
      @(posedge pixelclk);
      n++;
    end
    chk(tag, wq.size(), 0);
  endtask

  task automatic wait_sq_empty(input string tag);
    int n = 0;
    while (sq.size() != 0 && n < 200) begin
      @(posedge pixelclk);
      n++;
    end
    chk(tag, sq.size(), 0);
  endtask

  task automatic push_clear();
    for (int i = 0; i < W; i++) wq.push_back({12'(i), 1'b0});
  endtask

  task automatic push_scan();
    for (int i = 0; i < W; i++) sq.push_back({12'(i), (i == 0), (i == W - 1)});
  endtask

  task automatic do_frame(input bit pre_req, input logic [11:0] a1, input logic [11:0] a2);
    wait_wq_empty("clear_done");
    #1;
    i_vs = 1'b1;
    if (pre_req) begin
      i_wr_req  = 1'b1;
      i_wr_addr = 12'd5;
    end
    @(posedge pixelclk); #1;
    if (a1 < W) wq.push_back({a1, 1'b1});
    i_wr_req  = 1'b1;
    i_wr_addr = a1;
    @(posedge pixelclk); #1;
    if (a2 < W) wq.push_back({a2, 1'b1});
    i_wr_addr = a2;
    @(posedge pixelclk); #1;
    i_wr_req = 1'b0;
    i_vs     = 1'b0;
    push_scan();
    push_clear();
    wait_sq_empty("scan_done");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge pixelclk);
    chk("outs_in_reset_pre_edge", all_outs, 0);
    @(negedge pixelclk);
    chk("outs_in_reset", all_outs, 0);
    @(posedge pixelclk); #1;
    reset = 1'b0;
    @(negedge pixelclk);
    chk("outs_after_reset", all_outs, 0);

    // Enable: 16 consecutive clear writes, then WAIT_VS.
    @(posedge pixelclk); #1;
    push_clear();
    i_en = 1'b1;
    @(posedge pixelclk);
    for (int i = 0; i < W; i++) begin
      @(negedge pixelclk);
      chk("clear_we", {63'd0, ram_we}, 64'd1);
    end
    @(negedge pixelclk);
    chk("wait_vs_we_busy", {62'd0, ram_we, busy}, 64'd1);
    chk("clear_all_seen", wq.size(), 0);
    @(posedge pixelclk);

    // First frame: request in WAIT_VS ignored, addr 20 dropped, addr 3 written.
    do_frame(1'b1, 12'd3, 12'd20);
    chk("accum_only_addr3", wq.size(), W);
    chk("no_overrun", {63'd0, overrun}, 64'd0);

    // Complete the first divider group, then 8 frames for two publishes.
    for (int f = 0; f < 3; f++) do_frame(1'b0, 12'($urandom_range(0, 15)), 12'($urandom_range(0, 31)));
    wait_wq_empty("clear_done_g1");
    chk("stb_first_group_cnt", stb_log.size(), 1);
    chk("stb_first_group_at", (stb_log.size() > 0) ? stb_log[0] : -1, 4);
    scan_done_cnt = 0;
    stb_cycles    = 0;
    stb_log.delete();
    for (int f = 0; f < 8; f++) do_frame(1'b0, 12'($urandom_range(0, 15)), 12'($urandom_range(0, 31)));
    wait_wq_empty("clear_done_g2");
    chk("stb_pulses", stb_log.size(), 2);
    chk("stb_cycles", stb_cycles, 2);
    chk("stb_after_scan4", (stb_log.size() > 0) ? stb_log[0] : -1, 4);
    chk("stb_after_scan8", (stb_log.size() > 1) ? stb_log[1] : -1, 8);

    // Frame start during CLEAR is a missed frame.
    do_frame(1'b0, 12'd2, 12'd9);
    #1;
    i_vs = 1'b1;
    @(posedge pixelclk);
    @(negedge pixelclk);
    chk("overrun_set", {63'd0, overrun}, 64'd1);
    chk("overrun_cnt_one", {56'd0, overrun_cnt}, {56'd0, CNT_ONE});
    wait_wq_empty("clear_done_ovr");
    #1;
    i_wr_req  = 1'b1;
    i_wr_addr = 12'd7;
    repeat (2) @(posedge pixelclk);
    #1;
    i_wr_req = 1'b0;
    i_vs     = 1'b0;
    @(posedge pixelclk);
    do_frame(1'b0, 12'd4, 12'd11);
    chk("overrun_sticky", {63'd0, overrun}, 64'd1);

    // Force many overruns by toggling vs continuously.
    mon_off = 1'b1;
    repeat (3000) begin
      @(posedge pixelclk); #1;
      i_vs = ~i_vs;
    end
    i_vs = 1'b0;
    @(negedge pixelclk);
    chk("overrun_cnt_sat", {56'd0, overrun_cnt}, {56'd0, CNT_SAT});
    @(posedge pixelclk); #1;
    i_en = 1'b0;
    for (int n = 0; n < 100 && busy; n++) @(posedge pixelclk);
    @(negedge pixelclk);
    chk("idle_after_disable", {63'd0, busy}, 64'd0);
    chk("overrun_kept_in_idle", {63'd0, overrun}, 64'd1);
    wq.delete();
    sq.delete();
    mon_off = 1'b0;
    push_clear();
    i_en = 1'b1;
    @(posedge pixelclk);
    @(negedge pixelclk);
    chk("overrun_cleared", {63'd0, overrun}, 64'd0);
    chk("overrun_cnt_cleared", {56'd0, overrun_cnt}, 64'd0);

    // Drop enable mid-scan: scan completes, then IDLE.
    wait_wq_empty("clear_done_dis");
    #1;
    i_vs = 1'b1;
    @(posedge pixelclk); #1;
    i_vs = 1'b0;
    push_scan();
    @(posedge pixelclk);
    repeat (5) @(posedge pixelclk);
    #1;
    i_en = 1'b0;
    wait_sq_empty("scan_done_dis");
    @(negedge pixelclk);
    chk("idle_busy_after_scan", {63'd0, busy}, 64'd0);
    chk("idle_outs_after_scan", all_outs, 0);

    // Reset mid-scan: outputs drop immediately, no publish.
    @(posedge pixelclk); #1;
    push_clear();
    i_en = 1'b1;
    wait_wq_empty("clear_done_rst");
    #1;
    i_vs = 1'b1;
    @(posedge pixelclk); #1;
    i_vs = 1'b0;
    push_scan();
    @(posedge pixelclk);
    repeat (4) @(posedge pixelclk);
    #1;
    mon_off    = 1'b1;
    stb_before = stb_cycles;
    reset      = 1'b1;
    @(negedge pixelclk);
    chk("outs_reset_asserted", all_outs, 0);
    @(posedge pixelclk);
    @(negedge pixelclk);
    chk("outs_after_mid_scan_reset", all_outs, 0);
    #1;
    reset = 1'b0;
    i_en  = 1'b0;
    @(negedge pixelclk);
    chk("outs_first_cycle_after", all_outs, 0);
    repeat (20) @(posedge pixelclk);
    chk("no_stb_after_reset", stb_cycles, stb_before);
    sq.delete();
    wq.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/proj_seq_ctrl.md
PROJ_SEQ_CTRL -- requirements
Module: proj_seq_ctrl

Interface
REQ-001 Parameter IMG_WIDTH_LINE, default 1920, sets the projection RAM depth in entries.
REQ-002 Parameter FRAME_DIV, default 4, sets the number of scanned frames per published result (range 1..15).
REQ-003 pixelclk  in  1  sole clock; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_en  in  1  sequencer enable.
REQ-006 i_vs  in  1  frame sync; frame start is a rising edge, frame end is a falling edge.
REQ-007 i_wr_req  in  1  pixel-path request to mark a projection bin.
REQ-008 i_wr_addr  in  12  bin index of the request.
REQ-009 ram_we / ram_waddr / ram_di  out  1/12/1  projection RAM write port.
REQ-010 ram_raddr  out  12  projection RAM read address (the RAM has 1-cycle read latency).
REQ-011 scan_valid / scan_addr  out  1/12  marks which cycles of RAM read data are valid, and the address each cycle belongs to.
REQ-012 scan_first / scan_last  out  1/1  pulses marking bin 0 and bin IMG_WIDTH_LINE-1 of a scan.
REQ-013 result_stb  out  1  one-cycle pulse telling the edge extractor to publish its registers.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 overrun  out  1  sticky flag for a missed frame.
REQ-016 overrun_cnt  out  8  missed-frame count.

Function
REQ-017 States: IDLE, CLEAR, WAIT_VS, ACCUM, SCAN, PUBLISH.
REQ-018 Frame edges come from i_vs and a registered copy of i_vs.
- The registered copy resets to 0.
- An edge is detected one cycle after i_vs changes.
REQ-019 IDLE: go to CLEAR when i_en=1.
REQ-020 CLEAR: write ram_di=0 to addresses 0..IMG_WIDTH_LINE-1, one per cycle (IMG_WIDTH_LINE cycles), then go to WAIT_VS.
REQ-021 WAIT_VS: go to ACCUM on a detected rising edge of i_vs.
REQ-022 ACCUM: each i_wr_req=1 with i_wr_addr<IMG_WIDTH_LINE is forwarded combinationally as ram_we=1, ram_waddr=i_wr_addr, ram_di=1.
- Requests with i_wr_addr>=IMG_WIDTH_LINE are dropped.
- A detected falling edge of i_vs moves the FSM to SCAN.
REQ-023 i_wr_req is ignored in every state except ACCUM.
REQ-024 SCAN: ram_raddr steps 0..IMG_WIDTH_LINE-1, one per cycle.
- scan_valid and scan_addr are the issued address delayed 1 cycle.
- The FSM leaves SCAN after the last data cycle, so SCAN lasts IMG_WIDTH_LINE+1 cycles.
REQ-025 The frame counter (4 bits) increments at the end of each SCAN.
- When it reaches FRAME_DIV-1 it wraps to 0 and the FSM enters PUBLISH.
- Otherwise the FSM goes to CLEAR.
REQ-026 PUBLISH: result_stb=1 for exactly one cycle, then go to CLEAR.
REQ-027 A frame-start edge detected in CLEAR, SCAN or PUBLISH is a missed frame.
- overrun is set to 1 and the FSM does not abort.
- The missed frame is skipped, and accumulation begins at the next rising edge seen in WAIT_VS.
REQ-028 If i_en drops, the FSM finishes the current SCAN or CLEAR and then enters IDLE.
- If i_en drops in WAIT_VS or ACCUM, the FSM enters IDLE on the next cycle.
- The frame counter resets to 0 on entry to IDLE.
REQ-029 overrun clears only on reset or on the IDLE->CLEAR transition.
REQ-030 Outputs are inactive when not in their owning state:
- ram_we=0 outside CLEAR and ACCUM.
- scan_valid=0 outside the SCAN data window.

Reset
REQ-031 On reset the FSM enters IDLE, and the frame counter and all address counters are 0.
REQ-032 Every output is 0 during reset and in the first cycle after it.
REQ-033 Reset asserted mid-SCAN or mid-CLEAR aborts immediately with no result_stb, and the RAM contents are undefined.

Configuration
REQ-034 Macro PROJ_SEQ_OVERRUN_CNT_EN, when defined, enables the overrun counter.
- overrun_cnt increments, saturating at 255, on each missed frame.
- It clears under the same conditions as overrun.
REQ-035 Without PROJ_SEQ_OVERRUN_CNT_EN, overrun_cnt is a constant 0 and no counter logic is built; the overrun flag is unaffected.

Structure
REQ-036 A shared package holds:
- the state enumeration;
- the address width constant (12);
- the frame counter width constant (4).
REQ-037 Frame edge detection is a sub-module, vs_edge_det, with outputs rise and fall.
- It is reusable by other projection blocks.
- All other logic is flat in proj_seq_ctrl.

Verification
REQ-038 Reset, then i_en=1 with IMG_WIDTH_LINE=16.
- Required: 16 consecutive ram_we=1 with ram_di=0 at addresses 0..15.
- Required: FSM in WAIT_VS on cycle 18.
REQ-039 Accumulate with requests at addresses 3 and 20 (IMG_WIDTH_LINE=16), a request during WAIT_VS, then i_vs falls.
- Required: only address 3 is written with di=1.
- Required: the scan produces scan_valid for addr 0..15, with scan_first at 0 and scan_last at 15.
REQ-040 FRAME_DIV=4 over 8 complete frames.
- Required: result_stb pulses exactly twice, each for 1 cycle, after scans 4 and 8.
REQ-041 i_vs rises during CLEAR.
- Required: overrun=1 and the frame is skipped.
- Required (macro defined): overrun_cnt=1; 300 forced overruns saturate it at 255.
REQ-042 Drop i_en mid-SCAN.
- Required: the scan completes all bins and the FSM then enters IDLE with busy=0.
REQ-043 Assert reset mid-SCAN.
- Required: next cycle all outputs are 0 and no result_stb is issued.
